// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the round-robin FIFO write-port arbiter.
// Contents: arbiter state encoding, default FIFO geometry constants, and the
// rr_pick() helper that finds the next valid requester in round-robin order.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ArbIdle  = 1'b0,
    ArbBurst = 1'b1
  } arb_state_e;

  localparam int unsigned DefDataWidth = 4;
  localparam int unsigned DefDepth     = 8;
  localparam int unsigned DefCntWidth  = 4;

  // Upper bound on requesters; owner/pointer indices are 3 bits wide.
  localparam int unsigned MaxReq = 8;

  // First set bit of valid, searching ptr, ptr+1, ... modulo num_req.
  // Returns ptr when nothing is valid; callers qualify with |valid.
  function automatic logic [2:0] rr_pick(input logic [MaxReq-1:0] valid,
                                         input logic [2:0]        ptr,
                                         input int unsigned       num_req);
    logic        found;
    logic [2:0]  pick;
    int unsigned idx;
    found = 1'b0;
    pick  = ptr;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= num_req) idx = idx - num_req;
      if ((k < num_req) && !found && valid[idx[2:0]]) begin
        found = 1'b1;
        pick  = idx[2:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search over NumReq request lines.
// Ports:
//   valid_i  request vector
//   ptr_i    index given first priority
//   idx_o    first valid index at or after ptr_i (wrapping); ptr_i if none
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NumReq = 4
) (
  input  logic [NumReq-1:0] valid_i,
  input  logic [2:0]        ptr_i,
  output logic [2:0]        idx_o
);

  logic [MaxReq-1:0] valid_pad;

  assign valid_pad = MaxReq'(valid_i);
  assign idx_o     = rr_pick(valid_pad, ptr_i, NumReq);

endmodule

// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// A grant costs one IDLE cycle, then the owner may push up to BURST_LEN beats
// at one beat per cycle. Flow control uses a local count of unpopped writes,
// bumped at accept time so the FIFO can never overflow.
// Optional: define FIFO_ARB_STATS_EN for per-requester saturating beat counters.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_valid/req_data/req_ready   per-requester handshake (ready is combinational)
//   fifo_wr_en/fifo_wr_data        registered FIFO write port
//   fifo_pop      consumer pop pulse fed back from the FIFO read side
//   occupancy     unpopped write count
//   grant_id      current/last owner, busy = in BURST
//   stat_cnt      8-bit accepted-beat counter per requester (0 if disabled)
module fifo_rr_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned DEPTH      = DefDepth,
  parameter int unsigned CNT_WIDTH  = DefCntWidth,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_pop,
  output logic [CNT_WIDTH-1:0]          occupancy,
  output logic [2:0]                    grant_id,
  output logic                          busy,
  output logic [NUM_REQ*8-1:0]          stat_cnt
);

  localparam int unsigned          BeatW     = $clog2(BURST_LEN + 1);
  localparam logic [CNT_WIDTH-1:0] DepthCnt  = CNT_WIDTH'(DEPTH);
  localparam logic [BeatW-1:0]     BurstLast = BeatW'(BURST_LEN);
  localparam logic [2:0]           LastReq   = 3'(NUM_REQ - 1);

  arb_state_e            state_q, state_d;
  logic [2:0]            rr_ptr_q, rr_ptr_d;
  logic [2:0]            owner_q, owner_d;
  logic [2:0]            pick;
  logic [BeatW-1:0]      beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]  occ_q, occ_d;
  logic                  wr_en_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  space_ok, pop_ok, own_valid, accept;
  logic [DATA_WIDTH-1:0] own_data;

  rr_picker #(
    .NumReq(NUM_REQ)
  ) u_picker (
    .valid_i(req_valid),
    .ptr_i  (rr_ptr_q),
    .idx_o  (pick)
  );

  // Pre-update count: a pop in the same cycle does not open space yet.
  assign space_ok = occ_q < DepthCnt;
  assign pop_ok   = fifo_pop & (occ_q != '0);

  always_comb begin
    own_valid = 1'b0;
    own_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == 3'(i)) begin
        own_valid = req_valid[i];
        own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign accept = (state_q == ArbBurst) & own_valid & space_ok;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ArbIdle;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      ArbIdle: begin
        if ((|req_valid) && space_ok) begin
          state_d    = ArbBurst;
          owner_d    = pick;
          beat_cnt_d = '0;
        end
      end
      ArbBurst: begin
        if (accept) beat_cnt_d = beat_cnt_q + BeatW'(1);
        // A full-FIFO stall keeps the grant; only burst end or owner drop releases it.
        if ((accept && (beat_cnt_d == BurstLast)) || !own_valid) begin
          state_d  = ArbIdle;
          rr_ptr_d = (owner_q == LastReq) ? 3'd0 : owner_q + 3'd1;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q == ArbBurst);
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (owner_q == 3'(i));
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (accept && !pop_ok) begin
      occ_d = occ_q + CNT_WIDTH'(1);
    end else if (!accept && pop_ok) begin
      occ_d = occ_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      occ_q   <= occ_d;
      wr_en_q <= accept;
      if (accept) wr_data_q <= own_data;
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign occupancy    = occ_q;
  assign grant_id     = owner_q;

`ifdef FIFO_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    logic [7:0] stat_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        stat_q <= '0;
      end else if (req_ready[g] && (stat_q != 8'hFF)) begin
        stat_q <= stat_q + 8'd1;
      end
    end
    assign stat_cnt[g*8 +: 8] = stat_q;
  end
`else
  assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Self-checking bench for fifo_rr_wr_arbiter (NUM_REQ=4, DEPTH=8, BURST_LEN=4).
// Write data is checked through a scoreboard filled at accept time; occupancy,
// ready and busy follow a cycle table; grant order is checked by hand sequences.
module tb_fifo_rr_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_wr_en;
  logic [3:0]  fifo_wr_data;
  logic        fifo_pop;
  logic [3:0]  occupancy;
  logic [2:0]  grant_id;
  logic        busy;
  logic [31:0] stat_cnt;

`ifdef FIFO_ARB_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  always #5 clk = ~clk;

  fifo_rr_wr_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .fifo_pop    (fifo_pop),
    .occupancy   (occupancy),
    .grant_id    (grant_id),
    .busy        (busy),
    .stat_cnt    (stat_cnt)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] exp_q[$];
  int         acc_log[$];
  int         sent[4];
  logic [3:0] pre_ready;

  typedef struct {
    logic [3:0] v;
    logic       pop;
    logic [3:0] rdy;
    logic       busy;
    logic [3:0] occ;
    logic       wr;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(input logic [3:0] v, input logic p, input logic [3:0] rdy,
                              input logic b, input logic [3:0] o, input logic w);
    vec_t t;
    t.v = v; t.pop = p; t.rdy = rdy; t.busy = b; t.occ = o; t.wr = w;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, sample ready before the edge, check the write after it.
  task automatic step(input logic r, input logic [3:0] v, input logic p);
    logic [3:0] acc;
    logic       exp_wr;
    logic [3:0] exp_d;
    rst       = r;
    req_valid = v;
    fifo_pop  = p;
    for (int i = 0; i < 4; i++) req_data[i*4 +: 4] = 4'((i << 2) | (sent[i] & 3));
    #1;
    pre_ready = req_ready;
    chk("ready_legal",
        32'(($onehot0(req_ready) && ((req_ready & ~req_valid) == 4'b0)) ? 1 : 0), 32'd1);
    acc = r ? 4'b0 : (req_valid & req_ready);
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        exp_q.push_back(req_data[i*4 +: 4]);
        acc_log.push_back(i);
        sent[i]++;
      end
    end
    if (r) exp_q.delete();
    exp_wr = (acc != 4'b0);
    @(posedge clk);
    #1;
    chk("wr_en", 32'(fifo_wr_en), 32'(exp_wr));
    if (exp_wr && fifo_wr_en && (exp_q.size() > 0)) begin
      exp_d = exp_q.pop_front();
      chk("wr_data", 32'(fifo_wr_data), 32'(exp_d));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Backpressure table: requester 0 alone, no pops until it stalls.
    tbl[0]  = mk(4'h1, 0, 4'h0, 1, 4'd0, 0);
    tbl[1]  = mk(4'h1, 0, 4'h1, 1, 4'd1, 1);
    tbl[2]  = mk(4'h1, 0, 4'h1, 1, 4'd2, 1);
    tbl[3]  = mk(4'h1, 0, 4'h1, 1, 4'd3, 1);
    tbl[4]  = mk(4'h1, 0, 4'h1, 0, 4'd4, 1);
    tbl[5]  = mk(4'h1, 0, 4'h0, 1, 4'd4, 0);
    tbl[6]  = mk(4'h1, 0, 4'h1, 1, 4'd5, 1);
    tbl[7]  = mk(4'h1, 0, 4'h1, 1, 4'd6, 1);
    tbl[8]  = mk(4'h1, 0, 4'h1, 1, 4'd7, 1);
    tbl[9]  = mk(4'h1, 0, 4'h1, 0, 4'd8, 1);
    tbl[10] = mk(4'h1, 0, 4'h0, 0, 4'd8, 0);
    tbl[11] = mk(4'h1, 0, 4'h0, 0, 4'd8, 0);
    tbl[12] = mk(4'h1, 1, 4'h0, 0, 4'd7, 0);
    tbl[13] = mk(4'h1, 0, 4'h0, 1, 4'd7, 0);
    tbl[14] = mk(4'h1, 0, 4'h1, 1, 4'd8, 1);
    tbl[15] = mk(4'h1, 0, 4'h0, 1, 4'd8, 0);
    tbl[16] = mk(4'h1, 1, 4'h0, 1, 4'd7, 0);
    tbl[17] = mk(4'h1, 1, 4'h1, 1, 4'd7, 1);
    tbl[18] = mk(4'h1, 0, 4'h1, 1, 4'd8, 1);
    tbl[19] = mk(4'h1, 0, 4'h0, 1, 4'd8, 0);
    tbl[20] = mk(4'h0, 1, 4'h0, 0, 4'd7, 0);
    for (int k = 21; k < 28; k++) tbl[k] = mk(4'h0, 1, 4'h0, 0, 4'(27 - k), 0);
    tbl[28] = mk(4'h0, 1, 4'h0, 0, 4'd0, 0);

    // Reset state
    rst = 1'b1; req_valid = '0; fifo_pop = 1'b0; req_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stat", stat_cnt, 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);

    for (int k = 0; k < 29; k++) begin
      step(1'b0, tbl[k].v, tbl[k].pop);
      chk($sformatf("tbl%0d_ready", k), 32'(pre_ready), 32'(tbl[k].rdy));
      chk($sformatf("tbl%0d_busy", k), 32'(busy), 32'(tbl[k].busy));
      chk($sformatf("tbl%0d_occ", k), 32'(occupancy), 32'(tbl[k].occ));
      chk($sformatf("tbl%0d_wr", k), 32'(fifo_wr_en), 32'(tbl[k].wr));
    end

    // Full rotation with a pop every cycle: bursts 0,1,2,3,0 of 4 beats each.
    step(1'b1, 4'h0, 1'b0);
    acc_log.delete();
    for (int s = 1; s <= 25; s++) begin
      step(1'b0, 4'hF, 1'b1);
      chk($sformatf("rot_busy_%0d", s), 32'(busy), 32'((s % 5) != 0));
      chk($sformatf("rot_grant_%0d", s), 32'(grant_id), 32'(((s - 1) / 5) % 4));
    end
    chk("rot_count", 32'(acc_log.size()), 32'd20);
    for (int k = 0; k < 20 && k < acc_log.size(); k++) begin
      chk($sformatf("rot_order_%0d", k), 32'(acc_log[k]), 32'((k / 4) % 4));
    end
    chk("rot_stat", stat_cnt, StatsOn ? 32'h0404_0408 : 32'd0);

    // Early release: requester 2 drops after 2 beats, pointer moves to 3.
    step(1'b1, 4'h0, 1'b0);
    acc_log.delete();
    step(1'b0, 4'b0100, 1'b0);
    chk("er_grant2", 32'(grant_id), 32'd2);
    step(1'b0, 4'b0100, 1'b0);
    step(1'b0, 4'b0100, 1'b0);
    chk("er_occ2", 32'(occupancy), 32'd2);
    step(1'b0, 4'b0000, 1'b0);
    chk("er_release", 32'(busy), 32'd0);
    step(1'b0, 4'b0010, 1'b0);
    chk("er_grant1", 32'(grant_id), 32'd1);
    step(1'b0, 4'b0010, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b1001, 1'b0);
    chk("er_grant3", 32'(grant_id), 32'd3);
    chk("er_count", 32'(acc_log.size()), 32'd3);
    if (acc_log.size() == 3) begin
      chk("er_order0", 32'(acc_log[0]), 32'd2);
      chk("er_order2", 32'(acc_log[2]), 32'd1);
    end

    // Reset during beat 2 of a burst drops the in-flight beat.
    step(1'b1, 4'h0, 1'b0);
    step(1'b0, 4'b0001, 1'b0);
    step(1'b0, 4'b0001, 1'b0);
    step(1'b1, 4'b0001, 1'b0);
    chk("mbr_ready_pre", 32'(pre_ready), 32'd1);
    chk("mbr_busy", 32'(busy), 32'd0);
    chk("mbr_occ", 32'(occupancy), 32'd0);
    chk("mbr_stat", stat_cnt, 32'd0);
    step(1'b0, 4'b0000, 1'b0);
    chk("mbr_idle", 32'(busy), 32'd0);

    // Saturation: 300 accepts from requester 0.
    step(1'b1, 4'h0, 1'b0);
    acc_log.delete();
    for (int c = 0; c < 1000 && acc_log.size() < 300; c++) step(1'b0, 4'b0001, 1'b1);
    chk("sat_accepts", 32'(acc_log.size()), 32'd300);
    chk("sat_stat0", 32'(stat_cnt[7:0]), StatsOn ? 32'd255 : 32'd0);
    chk("sat_other", 32'(stat_cnt[31:8]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rr_wr_arbiter.md
Name: fifo_rr_wr_arbiter

Overview:
Shares the write port of the team's small synchronous FIFO (4-bit data, 8 entries) between NUM_REQ independent producers.
- Round-robin arbitration with per-grant bursts of up to BURST_LEN beats.
- Flow control from an internal occupancy counter; the FIFO full flag is not used.
- Registered write outputs drive the FIFO directly; the FIFO read side stays with the consumer, whose pop pulse is fed back here.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 4, FIFO data width
DEPTH, 8, FIFO entries; the arbiter never issues more than DEPTH unpopped writes
CNT_WIDTH, 4, occupancy counter width, must hold 0..DEPTH
BURST_LEN, 4, maximum beats per grant before rotation (>=1)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  requester i has a beat
req_data  in  NUM_REQ*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  beat accepted this cycle when valid&ready (combinational)
fifo_wr_en  out  1  registered FIFO write enable
fifo_wr_data  out  DATA_WIDTH  registered FIFO write data
fifo_pop  in  1  consumer read enable that actually pops the FIFO
occupancy  out  CNT_WIDTH  arbiter's count of unpopped writes
grant_id  out  3  current/last owner index
busy  out  1  high in BURST state
stat_cnt  out  NUM_REQ*8  per-requester accepted-beat counters (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge) sets:
  - state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, occupancy=0.
  - fifo_wr_en=0, fifo_wr_data=0, grant_id=0, busy=0, stat_cnt=0.
  - Reset mid-burst drops the burst; the beat in flight is lost. The FIFO must be reset in the same cycle.
- State machine:
  - IDLE: if any req_valid and occupancy<DEPTH, latch owner = first valid index searching rr_ptr, rr_ptr+1, ... mod NUM_REQ, then go to BURST. No beat is accepted in IDLE, so a grant costs one cycle.
  - BURST: req_ready[owner] = req_valid[owner] & (occupancy<DEPTH). All other req_ready are 0.
    - Each accept increments beat_cnt.
    - Go to IDLE and set rr_ptr=(owner+1) mod NUM_REQ when the accept makes beat_cnt==BURST_LEN, or when req_valid[owner]==0 in a BURST cycle.
    - Stalls caused by occupancy==DEPTH keep the grant.
- Write path:
  - An accept at cycle t gives fifo_wr_en=1 with fifo_wr_data=req_data[owner] in cycle t+1. Otherwise fifo_wr_en=0 and fifo_wr_data holds its last value.
  - Maximum throughput is 1 beat/cycle within a burst.
- Occupancy:
  - +1 on accept, -1 on fifo_pop when occupancy>0.
  - Accept and pop in the same cycle leave it unchanged.
  - fifo_pop at occupancy 0 is ignored.
  - Increment happens at accept, one cycle before the FIFO write, so the count is conservative and the FIFO never overflows.
- Ready at occupancy DEPTH-1 with a simultaneous pop: ready uses the pre-update count, so it is still 1.
- grant_id = owner (updated on IDLE->BURST). busy = (state==BURST).
- rr_ptr wraps NUM_REQ-1 -> 0.

Optional Feature:
FIFO_ARB_STATS_EN
- Defined: stat_cnt[i*8 +: 8] increments on each accept from requester i, saturates at 255, and clears on rst.
- Undefined: stat_cnt is tied to 0 and no counters are synthesized.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - state encoding (ARB_IDLE=0, ARB_BURST=1);
  - default constants for DATA_WIDTH, DEPTH, CNT_WIDTH;
  - a function rr_pick(valid, ptr) returning the next index.
- One natural sub-module: rr_picker, the combinational round-robin search over NUM_REQ. Everything else stays in fifo_rr_wr_arbiter.

Test Plan:
- Reset check: after rst, all outputs are 0. req_valid=4'b1111 asserted the cycle after reset -> cycle 1 is IDLE, grant_id=0, busy rises in cycle 2, first fifo_wr_en in cycle 3.
- Full rotation: all four requesters valid continuously with pop every cycle -> bursts of 4 beats in order 0,1,2,3,0; one idle cycle between bursts; data appears on fifo_wr_data one cycle after each accept.
- Early release: requester 2 alone drops valid after 2 beats -> return to IDLE after 2 writes, rr_ptr=3; next valid requester 1 is granted only after requesters 3,0 are skipped.
- Backpressure: no pops, requester 0 streams -> exactly 8 writes, occupancy=8, req_ready[0]=0. One fifo_pop -> occupancy 7, ready=1 next cycle, one more write, burst continues.
- Simultaneous accept and pop at occupancy 8->7->7: occupancy stays 7. fifo_pop at occupancy 0 -> stays 0.
- Mid-burst reset: rst during beat 2 of a burst -> next cycle state IDLE, occupancy=0, fifo_wr_en=0. With FIFO_ARB_STATS_EN, stat_cnt counts accepts per requester, reads 0 after rst, and saturates at 255 after 300 accepts.
